// File: rtl/dmem_ctrl_if.sv
// Bundle between the MA stage, the data-memory controller and the data bus.
// Signal suffixes (_i/_o) are named from the controller's point of view.
interface dmem_ctrl_if;
  logic        req_valid_i;
  logic        req_wr_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_sign_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        resp_o;
  logic        fault_o;
  logic        misalign_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  // Controller side.
  modport slave (
    input  req_valid_i, req_wr_i, req_addr_i, req_wdata_i, req_size_i, req_sign_i,
    input  bus_ack_i, bus_rdata_i,
    output stall_o, rdata_o, resp_o, fault_o, misalign_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o
  );

  // Pipeline + bus-model side.
  modport master (
    output req_valid_i, req_wr_i, req_addr_i, req_wdata_i, req_size_i, req_sign_i,
    output bus_ack_i, bus_rdata_i,
    input  stall_o, rdata_o, resp_o, fault_o, misalign_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o
  );
endinterface

// File: rtl/dmem_ctrl.sv
// MA-stage data-memory controller: one req/ack bus transaction per load/store.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned accesses skip the bus and flag misalign_o.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_i,
  dmem_ctrl_if.slave dm
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_addr_lo;
  logic [1:0]       r_size;
  logic             r_sign;
  logic [31:0]      r_rdata;
  logic             r_resp;
  logic             r_fault;
  logic             r_bus_req;
  logic             r_bus_we;
  logic [31:0]      r_bus_addr;
  logic [3:0]       r_bus_be;
  logic [31:0]      r_bus_wdata;

  // Half enables shift by the full byte offset so a misaligned half at offset 3
  // truncates to the top lane only.
  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   f_be = 4'b0001 << lo;
      2'b01:   f_be = 4'b0011 << lo;
      default: f_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   f_wdata = {4{wd[7:0]}};
      2'b01:   f_wdata = {2{wd[15:0]}};
      default: f_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] word, input logic [1:0] lo,
                                         input logic [1:0] size, input logic sign);
    logic [31:0] v_sh;
    logic        v_msb;
    v_sh = word >> {lo, 3'b000};
    case (size)
      2'b00: begin
        v_msb  = sign & v_sh[7];
        f_load = {{24{v_msb}}, v_sh[7:0]};
      end
      2'b01: begin
        v_msb  = sign & v_sh[15];
        f_load = {{16{v_msb}}, v_sh[15:0]};
      end
      default: f_load = v_sh;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  logic w_misal;
  logic r_misal;
  assign w_misal = ((dm.req_size_i == 2'b01) && dm.req_addr_i[0]) ||
                   (dm.req_size_i[1] && (dm.req_addr_i[1:0] != 2'b00));
  assign dm.misalign_o = r_misal;
`else
  assign dm.misalign_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr_lo   <= 2'b00;
      r_size      <= 2'b00;
      r_sign      <= 1'b0;
      r_rdata     <= '0;
      r_resp      <= 1'b0;
      r_fault     <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
      r_misal     <= 1'b0;
`endif
    end else begin
      r_resp  <= 1'b0;
      r_fault <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      r_misal <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (dm.req_valid_i) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            if (w_misal) begin
              r_rdata <= '0;
              r_resp  <= 1'b1;
              r_misal <= 1'b1;
              r_state <= S_RESP;
            end else
`endif
            begin
              r_addr_lo   <= dm.req_addr_i[1:0];
              r_size      <= dm.req_size_i;
              r_sign      <= dm.req_sign_i;
              r_cnt       <= '0;
              r_bus_req   <= 1'b1;
              r_bus_we    <= dm.req_wr_i;
              r_bus_addr  <= {dm.req_addr_i[31:2], 2'b00};
              r_bus_be    <= f_be(dm.req_size_i, dm.req_addr_i[1:0]);
              r_bus_wdata <= f_wdata(dm.req_size_i, dm.req_wdata_i);
              r_state     <= S_BUS;
            end
          end
        end
        S_BUS: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (dm.bus_ack_i) begin
            r_rdata   <= f_load(dm.bus_rdata_i, r_addr_lo, r_size, r_sign);
            r_bus_req <= 1'b0;
            r_resp    <= 1'b1;
            r_state   <= S_RESP;
          end else if ((TIMEOUT_CYC != 0) && (r_cnt == CNT_LAST)) begin
            r_rdata   <= '0;
            r_bus_req <= 1'b0;
            r_resp    <= 1'b1;
            r_fault   <= 1'b1;
            r_state   <= S_RESP;
          end else if (TIMEOUT_CYC != 0) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_bus_req <= 1'b0;
        end
      endcase
    end
  end

  // Stall drops in RESP so the MA/WB register captures rdata_o that cycle.
  assign dm.stall_o     = ((r_state == S_IDLE) && dm.req_valid_i) || (r_state == S_BUS);
  assign dm.rdata_o     = r_rdata;
  assign dm.resp_o      = r_resp;
  assign dm.fault_o     = r_fault;
  assign dm.bus_req_o   = r_bus_req;
  assign dm.bus_we_o    = r_bus_we;
  assign dm.bus_addr_o  = r_bus_addr;
  assign dm.bus_be_o    = r_bus_be;
  assign dm.bus_wdata_o = r_bus_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl (TIMEOUT_CYC = 4); honours DMEM_MISALIGN_TRAP_EN if defined.
module tb_dmem_ctrl;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic        mis;
  } resp_t;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  dmem_ctrl_if dm();

  dmem_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .dm    (dm)
  );

  int    n_vec = 0;
  int    n_mis = 0;
  bus_t  exp_bus[$];
  resp_t exp_resp[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] r;
    if (sz == 2'b00) begin
      case (lo)
        2'd0: r = 4'b0001;
        2'd1: r = 4'b0010;
        2'd2: r = 4'b0100;
        default: r = 4'b1000;
      endcase
    end else if (sz == 2'b01) begin
      case (lo)
        2'd0: r = 4'b0011;
        2'd1: r = 4'b0110;
        2'd2: r = 4'b1100;
        default: r = 4'b1000;
      endcase
    end else begin
      r = 4'b1111;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    if (sz == 2'b01) return {wd[15:0], wd[15:0]};
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [31:0] w, input logic [1:0] lo,
                                       input logic [1:0] sz, input logic sg);
    logic [31:0] s;
    s = w >> (int'(lo) * 8);
    if (sz == 2'b00) return (sg && s[7])  ? (32'hFFFFFF00 | {24'h0, s[7:0]})  : {24'h0, s[7:0]};
    if (sz == 2'b01) return (sg && s[15]) ? (32'hFFFF0000 | {16'h0, s[15:0]}) : {16'h0, s[15:0]};
    return s;
  endfunction

  // Monitor: compares the first cycle of every bus request and every response pulse.
  logic  prev_req = 1'b0;
  bus_t  mb;
  resp_t mr;
  always @(negedge clk) begin
    if (rst_i) begin
      prev_req = 1'b0;
    end else begin
      if (dm.bus_req_o && !prev_req) begin
        if (exp_bus.size() == 0) begin
          chk("spurious_bus_req", 32'(dm.bus_req_o), 32'h0);
        end else begin
          mb = exp_bus.pop_front();
          chk("bus_we",    32'(dm.bus_we_o), 32'(mb.we));
          chk("bus_addr",  dm.bus_addr_o,    mb.addr);
          chk("bus_be",    32'(dm.bus_be_o), 32'(mb.be));
          chk("bus_wdata", dm.bus_wdata_o,   mb.wdata);
        end
      end
      if (dm.resp_o) begin
        if (exp_resp.size() == 0) begin
          chk("spurious_resp", 32'(dm.resp_o), 32'h0);
        end else begin
          mr = exp_resp.pop_front();
          chk("rdata",    dm.rdata_o,             mr.rdata);
          chk("fault",    32'(dm.fault_o),        32'(mr.fault));
          chk("misalign", 32'(dm.misalign_o),     32'(mr.mis));
          chk("resp_stall", 32'(dm.stall_o),      32'h0);
        end
      end
      prev_req = dm.bus_req_o;
    end
  end

  // One transaction; dly < 0 means never ack. Entered and left at #1 after a posedge in IDLE.
  task automatic run(input string nm, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic sg, input logic [31:0] brd, input int dly);
    bus_t  b;
    resp_t r;
    logic  mis, skip;
    int    lat_exp, c;
    mis  = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
    skip = TRAP && mis;
    b.we = wr; b.addr = {a[31:2], 2'b00}; b.be = m_be(sz, a[1:0]); b.wdata = m_wd(sz, wd);
    if (!skip) exp_bus.push_back(b);
    r.fault = !skip && (dly < 0);
    r.mis   = skip;
    r.rdata = (skip || dly < 0) ? 32'h0 : m_ld(brd, a[1:0], sz, sg);
    exp_resp.push_back(r);
    lat_exp = skip ? 1 : ((dly < 0) ? 5 : dly + 2);

    dm.req_valid_i = 1'b1; dm.req_wr_i = wr; dm.req_addr_i = a;
    dm.req_wdata_i = wd;   dm.req_size_i = sz; dm.req_sign_i = sg;
    dm.bus_rdata_i = brd;
    #1 chk({nm, "_stall"}, 32'(dm.stall_o), 32'h1);
    c = 0;
    while (c < 40) begin
      @(posedge clk); #1; c++;
      if (dm.resp_o) break;
      if (dm.bus_req_o) chk({nm, "_hold_addr"}, dm.bus_addr_o, b.addr);
      dm.bus_ack_i = (dly >= 0) && (c == dly + 1);
    end
    dm.bus_ack_i = 1'b0;
    dm.req_valid_i = 1'b0;
    chk({nm, "_latency"}, 32'(c), 32'(lat_exp));
    chk({nm, "_req_drop"}, 32'(dm.bus_req_o), 32'h0);
    @(posedge clk); #1;
    chk({nm, "_one_pulse"}, 32'(dm.resp_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rw;
    logic [1:0]  rs;
    dm.req_valid_i = 1'b0; dm.req_wr_i = 1'b0; dm.req_addr_i = '0; dm.req_wdata_i = '0;
    dm.req_size_i = 2'b00; dm.req_sign_i = 1'b0; dm.bus_ack_i = 1'b0; dm.bus_rdata_i = '0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", 32'(dm.bus_req_o), 32'h0);
    chk("rst_bus_we",  32'(dm.bus_we_o),  32'h0);
    chk("rst_bus_addr", dm.bus_addr_o,    32'h0);
    chk("rst_bus_be",  32'(dm.bus_be_o),  32'h0);
    chk("rst_bus_wdata", dm.bus_wdata_o,  32'h0);
    chk("rst_rdata",   dm.rdata_o,        32'h0);
    chk("rst_resp",    32'(dm.resp_o),    32'h0);
    chk("rst_fault",   32'(dm.fault_o),   32'h0);
    chk("rst_misal",   32'(dm.misalign_o), 32'h0);
    chk("rst_stall",   32'(dm.stall_o),   32'h0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    run("lw_100",  1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 2);
    run("lb_103",  1'b0, 32'h103, 32'h0,        2'b00, 1'b1, 32'h80000000, 0);
    run("lbu_103", 1'b0, 32'h103, 32'h0,        2'b00, 1'b0, 32'h80000000, 1);
    run("sh_102",  1'b1, 32'h102, 32'h1234ABCD, 2'b01, 1'b0, 32'h0,        1);
    run("sb_101",  1'b1, 32'h101, 32'h0000005A, 2'b00, 1'b0, 32'h0,        0);
    run("lh_102",  1'b0, 32'h102, 32'h0,        2'b01, 1'b1, 32'h8001F00F, 0);
    run("lhu_100", 1'b0, 32'h100, 32'h0,        2'b01, 1'b0, 32'h8001F00F, 3);
    run("lw_sz3",  1'b0, 32'h204, 32'h0,        2'b11, 1'b0, 32'h13579BDF, 0);
    run("timeout", 1'b0, 32'h200, 32'h0,        2'b10, 1'b0, 32'hFFFFFFFF, -1);
    run("ack_at_timeout", 1'b0, 32'h208, 32'h0, 2'b10, 1'b0, 32'h0BADF00D, 3);
    run("lw_mis",  1'b0, 32'h102, 32'h0,        2'b10, 1'b0, 32'hCAFEF00D, 1);
    run("sw_mis",  1'b1, 32'h301, 32'h11223344, 2'b10, 1'b0, 32'h0,        0);
    run("lh_mis3", 1'b0, 32'h103, 32'h0,        2'b01, 1'b1, 32'h8F000000, 0);

    for (int i = 0; i < 8; i++) begin
      rs = 2'($urandom_range(0, 2));
      ra = $urandom;
      if (rs == 2'b01) ra[0] = 1'b0;
      if (rs == 2'b10) ra[1:0] = 2'b00;
      rw = $urandom;
      run("rand", 1'($urandom_range(0, 1)), ra, rw, rs, 1'($urandom_range(0, 1)),
          $urandom, int'($urandom_range(0, 3)));
    end

    // Ack with no transaction in flight must be ignored.
    dm.bus_ack_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_ack_resp", 32'(dm.resp_o), 32'h0);
      chk("idle_ack_req",  32'(dm.bus_req_o), 32'h0);
    end
    dm.bus_ack_i = 1'b0;

    // Reset while BUS: request drops asynchronously and a late ack produces nothing.
    exp_bus.push_back('{we: 1'b0, addr: 32'h300, be: 4'hF, wdata: 32'h0});
    dm.req_valid_i = 1'b1; dm.req_wr_i = 1'b0; dm.req_addr_i = 32'h300;
    dm.req_size_i = 2'b10; dm.req_wdata_i = 32'h0;
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(dm.bus_req_o), 32'h1);
    dm.req_valid_i = 1'b0;
    @(negedge clk); #1;
    rst_i = 1'b1;
    #1;
    chk("rst_async_req", 32'(dm.bus_req_o), 32'h0);
    chk("rst_async_stall", 32'(dm.stall_o), 32'h0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    dm.bus_ack_i = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_resp", 32'(dm.resp_o), 32'h0);
    end
    dm.bus_ack_i = 1'b0;
    @(posedge clk); #1;
    run("after_rst", 1'b0, 32'h400, 32'h0, 2'b00, 1'b1, 32'h00007F00, 0);

    chk("bus_queue_left",  32'(exp_bus.size()),  32'h0);
    chk("resp_queue_left", 32'(exp_resp.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
